// File: rtl/ps2_arrow_key_decoder_pkg.sv
// Shared PS/2 scan-code constants and decoder FSM encoding.
// Other PS/2 consumers import ps2_pkg to get the same prefix codes.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_CODE_LEFT    = 8'h6B;
  localparam logic [7:0] PS2_CODE_RIGHT   = 8'h74;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_EXT_ENC     = 2'd1;
  localparam logic [1:0] ST_BRK_ENC     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_EXT     = ST_EXT_ENC,
    ST_BRK     = ST_BRK_ENC,
    ST_EXT_BRK = ST_EXT_BRK_ENC
  } ps2_state_e;

  typedef struct packed {
    logic left_key;
    logic right_key;
    logic left_held;
    logic right_held;
  } key_out_t;

endpackage

// File: rtl/ps2_arrow_key_decoder_if.sv
// Byte stream from the PS/2 receiver and arrow-key outputs to the alarm FSM.
// master = receiver/consumer side, slave = the decoder.
interface ps2_arrow_key_decoder_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       left_key;
  logic       right_key;
  logic       left_held;
  logic       right_held;

  modport master (
    output rx_data, rx_valid, rx_err,
    input  left_key, right_key, left_held, right_held
  );

  modport slave (
    input  rx_data, rx_valid, rx_err,
    output left_key, right_key, left_held, right_held
  );

endinterface

// File: rtl/ps2_arrow_key_decoder_timeout.sv
// Idle-cycle counter for discarding a stale PS/2 prefix; expired is high
// while enabled and the count has reached CYCLES-1.
module ps2_prefix_timeout #(
  parameter int unsigned CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/ps2_arrow_key_decoder.sv
// Turns PS/2 scan-code bytes into one-shot left/right arrow make pulses plus
// held levels. Define PS2_TYPEMATIC_EN to pulse on typematic repeats too.
module ps2_arrow_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0]  CODE_LEFT      = PS2_CODE_LEFT,
  parameter logic [7:0]  CODE_RIGHT     = PS2_CODE_RIGHT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ps2_arrow_key_decoder_if.slave   bus
);

  ps2_state_e state, state_n;
  key_out_t   out_q, out_n;
  logic       expired;

  ps2_prefix_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.rx_valid || bus.rx_err || (state == ST_IDLE)),
    .enable  (state != ST_IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      out_q <= '0;
    end else begin
      state <= state_n;
      out_q <= out_n;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n           = state;
    out_n             = out_q;
    out_n.left_key    = 1'b0;
    out_n.right_key   = 1'b0;

    if (bus.rx_err) begin
      state_n = ST_IDLE;
    end else if (bus.rx_valid) begin
      state_n = ST_IDLE;
      unique case (state)
        ST_IDLE: begin
          if (bus.rx_data == PS2_EXT_PREFIX)        state_n = ST_EXT;
          else if (bus.rx_data == PS2_BREAK_PREFIX) state_n = ST_BRK;
        end
        ST_EXT: begin
          if (bus.rx_data == PS2_BREAK_PREFIX) begin
            state_n = ST_EXT_BRK;
          end else if (bus.rx_data == PS2_EXT_PREFIX) begin
            state_n = ST_EXT;
          end else if (bus.rx_data == CODE_LEFT) begin
            out_n.left_held = 1'b1;
`ifdef PS2_TYPEMATIC_EN
            out_n.left_key  = 1'b1;
`else
            out_n.left_key  = !out_q.left_held;
`endif
          end else if (bus.rx_data == CODE_RIGHT) begin
            out_n.right_held = 1'b1;
`ifdef PS2_TYPEMATIC_EN
            out_n.right_key  = 1'b1;
`else
            out_n.right_key  = !out_q.right_held;
`endif
          end
        end
        ST_BRK: ;
        ST_EXT_BRK: begin
          if (bus.rx_data == CODE_LEFT)       out_n.left_held  = 1'b0;
          else if (bus.rx_data == CODE_RIGHT) out_n.right_held = 1'b0;
        end
        default: ;
      endcase
    end else if (expired) begin
      // A prefix whose follow-up byte never arrived is dropped; held bits stay.
      state_n = ST_IDLE;
    end
  end

  assign bus.left_key   = out_q.left_key;
  assign bus.right_key  = out_q.right_key;
  assign bus.left_held  = out_q.left_held;
  assign bus.right_held = out_q.right_held;

endmodule

// File: tb/tb_ps2_arrow_key_decoder.sv
// Directed bench for ps2_arrow_key_decoder with a 16-cycle prefix timeout.
module tb_ps2_arrow_key_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ps2_arrow_key_decoder_if bus ();

  ps2_arrow_key_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef PS2_TYPEMATIC_EN
  localparam int REPEAT_PULSE = 1;
`else
  localparam int REPEAT_PULSE = 0;
`endif

  int vectors = 0;
  int fails   = 0;

  // Pulse monitor: counts pulses, timestamps them, flags adjacency/overlap.
  int  cyc = 0, left_cnt = 0, right_cnt = 0, left_t = 0, right_t = 0;
  int  adj_cnt = 0, ovl_cnt = 0;
  logic prev_pulse = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.left_key === 1'b1)  begin left_cnt  = left_cnt + 1;  left_t  = cyc; end
    if (bus.right_key === 1'b1) begin right_cnt = right_cnt + 1; right_t = cyc; end
    if ((bus.left_key === 1'b1) && (bus.right_key === 1'b1)) ovl_cnt = ovl_cnt + 1;
    if (((bus.left_key === 1'b1) || (bus.right_key === 1'b1)) && prev_pulse) adj_cnt = adj_cnt + 1;
    prev_pulse = (bus.left_key === 1'b1) || (bus.right_key === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send_err();
    @(negedge clk);
    bus.rx_err = 1'b1;
    @(negedge clk);
    bus.rx_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic lk, input logic rk,
                            input logic lh, input logic rh);
    check({tag, ".left_key"},   {31'd0, bus.left_key},   {31'd0, lk});
    check({tag, ".right_key"},  {31'd0, bus.right_key},  {31'd0, rk});
    check({tag, ".left_held"},  {31'd0, bus.left_held},  {31'd0, lh});
    check({tag, ".right_held"}, {31'd0, bus.right_held}, {31'd0, rh});
  endtask

  initial begin
    int l0, r0, a0, o0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_err = 1'b0;

    // Reset, with a left make presented while reset is held (must be ignored).
    idle(2);
    send_byte(8'hE0);
    send_byte(8'h6B);
    check_outs("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(1);

    // Left make: one pulse, the cycle after the 6B strobe.
    send_byte(8'hE0);
    send_byte(8'h6B);
    check_outs("left_make", 1, 0, 1, 0);
    idle(1);
    check("left_make.one_cycle", {31'd0, bus.left_key}, 32'd0);

    // Right make, typematic repeat, release.
    r0 = right_cnt;
    send_byte(8'hE0);
    send_byte(8'h74);
    check_outs("right_make", 0, 1, 1, 1);
    send_byte(8'hE0);
    send_byte(8'h74);
    check("right_repeat.key", {31'd0, bus.right_key}, REPEAT_PULSE);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    check_outs("right_break", 0, 0, 1, 0);
    idle(2); #1;
    check("right_pulse_count", right_cnt - r0, 1 + REPEAT_PULSE);

    // Release left, then non-extended make/break must be ignored.
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    check_outs("left_break", 0, 0, 0, 0);
    l0 = left_cnt;
    send_byte(8'h6B);
    send_byte(8'hF0);
    send_byte(8'h6B);
    idle(2); #1;
    check("nonext.pulses", left_cnt - l0, 0);
    check_outs("nonext", 0, 0, 0, 0);
    send_byte(8'hE0);
    send_byte(8'h6B);
    check_outs("nonext.back_in_idle", 1, 0, 1, 0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);

    // Timeout: 6B sampled 20 cycles after E0 is dropped, 10 cycles after is a make.
    l0 = left_cnt;
    send_byte(8'hE0);
    idle(18);
    send_byte(8'h6B);
    check_outs("timeout.expired", 0, 0, 0, 0);
    send_byte(8'hE0);
    idle(8);
    send_byte(8'h6B);
    check_outs("timeout.in_time", 1, 0, 1, 0);
    idle(1); #1;
    check("timeout.pulse_count", left_cnt - l0, 1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);

    // rx_err discards the pending prefix.
    send_byte(8'hE0);
    send_err();
    send_byte(8'h6B);
    check_outs("rx_err", 0, 0, 0, 0);

    // Reset mid-sequence while left is held.
    send_byte(8'hE0);
    send_byte(8'h6B);
    send_byte(8'hE0);
    check("pre_reset.left_held", {31'd0, bus.left_held}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_data = 8'h74; bus.rx_valid = 1'b1;
    @(negedge clk);
    check_outs("mid_reset", 0, 0, 0, 0);
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    rst_n = 1'b1;
    idle(1);

    // Interleaved E0,6B,E0,74 strobes three cycles apart.
    l0 = left_cnt; r0 = right_cnt; a0 = adj_cnt; o0 = ovl_cnt;
    send_byte(8'hE0); idle(1);
    send_byte(8'h6B); idle(1);
    send_byte(8'hE0); idle(1);
    send_byte(8'h74); idle(3); #1;
    check("inter.left_pulses",  left_cnt - l0, 1);
    check("inter.right_pulses", right_cnt - r0, 1);
    check("inter.pulse_spacing", right_t - left_t, 6);
    check("inter.adjacent", adj_cnt - a0, 0);
    check("inter.overlap",  ovl_cnt - o0, 0);
    check_outs("inter", 0, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
